mc_controller: RTL and testbench
================================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16: maximum wait cycles per memory handshake before fault.
REQ-002 Parameter ALUFN_W, default 5: alufn width.
REQ-003 Clocking: one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous active-high reset.
REQ-006 enable  in  1  processor run enable; 0 freezes the FSM.
REQ-007 op  in  6  instruction opcode (from external IR).
REQ-008 func  in  6  R-type function field.
REQ-009 Z  in  1  ALU zero flag.
REQ-010 mem_ready  in  1  memory completion for the current request.
REQ-011 mem_req  out  1  memory request (fetch or data).
REQ-012 mem_we  out  1  data-memory write, valid with mem_req.
REQ-013 irwrite  out  1  IR load strobe.
REQ-014 pcwrite  out  1  PC update strobe.
REQ-015 werf  out  1  register-file write strobe.
REQ-016 pcsel, wasel, wdsel, asel  out  2 each  datapath mux selects, same encodings as the single-cycle controller.
REQ-017 sext, bsel  out  1 each  sign-extend control and ALU-B select.
REQ-018 alufn  out  ALUFN_W  ALU function.
REQ-019 state  out  3  current state code, for debug.
REQ-020 fault  out  1  sticky illegal-instruction or timeout indication.

Function
REQ-021 States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=5.
REQ-022 FETCH: mem_req=1, mem_we=0.
REQ-023 FETCH, on mem_ready: irwrite=1 for exactly that cycle, then go to DECODE.
REQ-024 DECODE: unrecognised op/func goes to FAULT; otherwise go to EXEC.
REQ-025 EXEC: drive alufn/asel/bsel/sext per instruction.
REQ-026 EXEC, BEQ/BNE/J/JR: pcwrite=1 and go to FETCH.
REQ-027 EXEC, LW/SW: go to MEM.
REQ-028 EXEC, all others: go to WB.
REQ-029 MEM: mem_req=1; mem_we=1 only for SW.
REQ-030 MEM, on mem_ready: SW asserts pcwrite=1 and goes to FETCH; LW goes to WB.
REQ-031 WB: werf=1 and pcwrite=1, then go to FETCH.
REQ-032 JAL/JALR write the link in WB with wdsel=00; JAL uses wasel=10.
REQ-033 pcsel: branch uses {0,Z} (BEQ) or {0,~Z} (BNE); J/JAL use 10; JR/JALR use 11; all others 00.
REQ-034 pcsel is meaningful only while pcwrite=1.
REQ-035 alufn and datapath-select encodings are identical to the single-cycle controller; don't-care bits are driven 0.
REQ-036 Latency at zero wait states (mem_ready same cycle as request): J/branch/JR 3 cycles; ALU/SW/JAL/JALR 4 cycles; LW 5 cycles.
REQ-037 Wait counter clears on every new request.
REQ-038 Wait counter increments each enabled cycle with mem_req=1 and mem_ready=0.
REQ-039 When the wait count equals TIMEOUT_CYC, go to FAULT.
REQ-040 If mem_ready and timeout occur in the same cycle, mem_ready wins.
REQ-041 enable=0: state and counter hold; mem_req, mem_we, irwrite, pcwrite and werf are forced 0.
REQ-042 FAULT: fault=1; all strobes and mem_req are 0; state exits only by reset.
REQ-043 werf, mem_we and pcwrite are never asserted in the same cycle as irwrite.

Reset
REQ-044 While reset=1: state=FETCH, counter=0, fault=0.
REQ-045 While reset=1: all strobes and mem_req are 0, and every select and alufn output is 0.
REQ-046 Reset asserted mid-handshake aborts the handshake with no strobe issued.
REQ-047 First mem_req rises on the first enabled clock after reset deasserts.

Structure
REQ-048 Package mc_pkg holds the state enum, opcode/func constants, alufn codes and mux-select codes.
REQ-049 Sub-module mc_alu_decoder is combinational: op/func in; alufn, select fields and illegal flag out.
REQ-050 mc_alu_decoder is instantiated once.
REQ-051 FSM state and wait counter are the only sequential elements.

Verification
REQ-052 ADD (op=0, func=100000), zero wait: irwrite cycle 1; cycle 4 has werf=1, pcwrite=1, alufn=00001, wdsel=01, wasel=00.
REQ-053 BEQ with Z=1: pcwrite=1 and pcsel=01 in EXEC (cycle 3); werf stays 0; FETCH in cycle 4.
REQ-054 LW with mem_ready delayed 3 cycles in MEM: mem_we=0 throughout; werf=1 in cycle 8; no timeout.
REQ-055 TIMEOUT_CYC=4, mem_ready held 0 in FETCH: FAULT entered after 4 wait cycles; fault=1; mem_req=0 thereafter; enable toggles have no effect.
REQ-056 op=111111: DECODE goes to FAULT, with no werf/mem_we/pcwrite ever asserted.
REQ-057 SW in MEM, enable dropped 2 cycles then reset pulsed: strobes 0 while frozen; after reset, state=FETCH and mem_we was never asserted.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle controller.
package mc_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  // How an instruction leaves EXEC
  typedef enum logic [2:0] {
    K_ALU   = 3'd0,
    K_LOAD  = 3'd1,
    K_STORE = 3'd2,
    K_JUMP  = 3'd3,
    K_LINK  = 3'd4
  } kind_t;

  // Conditional branch flavour; resolved against Z by the controller
  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_EQ   = 2'd1,
    BR_NE   = 2'd2
  } br_t;

  // Decoded per-instruction controls; all-zero for an illegal instruction
  typedef struct packed {
    kind_t      kind;
    br_t        br;
    logic [1:0] pcsel;
    logic [1:0] wasel;
    logic [1:0] wdsel;
    logic [1:0] asel;
    logic       sext;
    logic       bsel;
  } dec_t;

  localparam int unsigned OP_W = 6;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'h0A;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OP_W-1:0] OP_XORI  = 6'h0E;
  localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  localparam logic [OP_W-1:0] F_SLL  = 6'h00;
  localparam logic [OP_W-1:0] F_SRL  = 6'h02;
  localparam logic [OP_W-1:0] F_SRA  = 6'h03;
  localparam logic [OP_W-1:0] F_JR   = 6'h08;
  localparam logic [OP_W-1:0] F_JALR = 6'h09;
  localparam logic [OP_W-1:0] F_ADD  = 6'h20;
  localparam logic [OP_W-1:0] F_SUB  = 6'h22;
  localparam logic [OP_W-1:0] F_AND  = 6'h24;
  localparam logic [OP_W-1:0] F_OR   = 6'h25;
  localparam logic [OP_W-1:0] F_XOR  = 6'h26;
  localparam logic [OP_W-1:0] F_NOR  = 6'h27;
  localparam logic [OP_W-1:0] F_SLT  = 6'h2A;
  localparam logic [OP_W-1:0] F_SLTU = 6'h2B;

  localparam int unsigned ALU_CODE_W = 5;

  localparam logic [ALU_CODE_W-1:0] ALU_NONE = 5'b00000;
  localparam logic [ALU_CODE_W-1:0] ALU_ADD  = 5'b00001;
  localparam logic [ALU_CODE_W-1:0] ALU_SUB  = 5'b00011;
  localparam logic [ALU_CODE_W-1:0] ALU_SLT  = 5'b01011;
  localparam logic [ALU_CODE_W-1:0] ALU_SLTU = 5'b01111;
  localparam logic [ALU_CODE_W-1:0] ALU_AND  = 5'b10000;
  localparam logic [ALU_CODE_W-1:0] ALU_OR   = 5'b10001;
  localparam logic [ALU_CODE_W-1:0] ALU_XOR  = 5'b10010;
  localparam logic [ALU_CODE_W-1:0] ALU_NOR  = 5'b10011;
  localparam logic [ALU_CODE_W-1:0] ALU_SLL  = 5'b11000;
  localparam logic [ALU_CODE_W-1:0] ALU_SRL  = 5'b11010;
  localparam logic [ALU_CODE_W-1:0] ALU_SRA  = 5'b11011;

  localparam logic [1:0] PCSEL_INC  = 2'b00;
  localparam logic [1:0] PCSEL_BR   = 2'b01;
  localparam logic [1:0] PCSEL_JMP  = 2'b10;
  localparam logic [1:0] PCSEL_REG  = 2'b11;

  localparam logic [1:0] WASEL_RD   = 2'b00;
  localparam logic [1:0] WASEL_RT   = 2'b01;
  localparam logic [1:0] WASEL_RA   = 2'b10;

  localparam logic [1:0] WDSEL_LINK = 2'b00;
  localparam logic [1:0] WDSEL_ALU  = 2'b01;
  localparam logic [1:0] WDSEL_MEM  = 2'b10;

  localparam logic [1:0] ASEL_SHAMT = 2'b01;
  localparam logic [1:0] ASEL_16    = 2'b10;

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> datapath/memory signal bundle; master is the controller.
interface mc_controller_if #(
  parameter int unsigned ALUFN_W = 5
);

  logic               enable;
  logic [5:0]         op;
  logic [5:0]         func;
  logic               Z;
  logic               mem_ready;

  logic               mem_req;
  logic               mem_we;
  logic               irwrite;
  logic               pcwrite;
  logic               werf;
  logic [1:0]         pcsel;
  logic [1:0]         wasel;
  logic [1:0]         wdsel;
  logic [1:0]         asel;
  logic               sext;
  logic               bsel;
  logic [ALUFN_W-1:0] alufn;
  logic [2:0]         state;
  logic               fault;

  modport master (
    input  enable, op, func, Z, mem_ready,
    output mem_req, mem_we, irwrite, pcwrite, werf,
    output pcsel, wasel, wdsel, asel, sext, bsel, alufn, state, fault
  );

  modport slave (
    output enable, op, func, Z, mem_ready,
    input  mem_req, mem_we, irwrite, pcwrite, werf,
    input  pcsel, wasel, wdsel, asel, sext, bsel, alufn, state, fault
  );

endinterface

// File: rtl/mc_alu_decoder.sv
// Combinational instruction decoder: op/func to ALU function and datapath selects.
module mc_alu_decoder
  import mc_pkg::*;
#(
  parameter int unsigned ALUFN_W = 5
) (
  input  logic [OP_W-1:0]    op_i,
  input  logic [OP_W-1:0]    func_i,
  output logic [ALUFN_W-1:0] alufn_o,
  output dec_t               sel_o,
  output logic               illegal_o
);

  logic [ALU_CODE_W-1:0] fn;

  // Per-opcode control table; unlisted encodings flag illegal with all controls 0
  always_comb begin
    fn        = ALU_NONE;
    sel_o     = '0;
    illegal_o = 1'b0;
    case (op_i)
      OP_RTYPE: begin
        sel_o.wasel = WASEL_RD;
        sel_o.wdsel = WDSEL_ALU;
        case (func_i)
          F_ADD:  fn = ALU_ADD;
          F_SUB:  fn = ALU_SUB;
          F_AND:  fn = ALU_AND;
          F_OR:   fn = ALU_OR;
          F_XOR:  fn = ALU_XOR;
          F_NOR:  fn = ALU_NOR;
          F_SLT:  fn = ALU_SLT;
          F_SLTU: fn = ALU_SLTU;
          F_SLL:  begin fn = ALU_SLL; sel_o.asel = ASEL_SHAMT; end
          F_SRL:  begin fn = ALU_SRL; sel_o.asel = ASEL_SHAMT; end
          F_SRA:  begin fn = ALU_SRA; sel_o.asel = ASEL_SHAMT; end
          F_JR: begin
            sel_o       = '0;
            sel_o.kind  = K_JUMP;
            sel_o.pcsel = PCSEL_REG;
          end
          F_JALR: begin
            sel_o.kind  = K_LINK;
            sel_o.pcsel = PCSEL_REG;
            sel_o.wdsel = WDSEL_LINK;
          end
          default: begin
            sel_o     = '0;
            illegal_o = 1'b1;
          end
        endcase
      end
      OP_ADDI: begin fn = ALU_ADD; sel_o.bsel = 1'b1; sel_o.sext = 1'b1;
                     sel_o.wasel = WASEL_RT; sel_o.wdsel = WDSEL_ALU; end
      OP_SLTI: begin fn = ALU_SLT; sel_o.bsel = 1'b1; sel_o.sext = 1'b1;
                     sel_o.wasel = WASEL_RT; sel_o.wdsel = WDSEL_ALU; end
      OP_ANDI: begin fn = ALU_AND; sel_o.bsel = 1'b1;
                     sel_o.wasel = WASEL_RT; sel_o.wdsel = WDSEL_ALU; end
      OP_ORI:  begin fn = ALU_OR;  sel_o.bsel = 1'b1;
                     sel_o.wasel = WASEL_RT; sel_o.wdsel = WDSEL_ALU; end
      OP_XORI: begin fn = ALU_XOR; sel_o.bsel = 1'b1;
                     sel_o.wasel = WASEL_RT; sel_o.wdsel = WDSEL_ALU; end
      // Upper immediate is the zero-extended immediate shifted left by 16
      OP_LUI:  begin fn = ALU_SLL; sel_o.bsel = 1'b1; sel_o.asel = ASEL_16;
                     sel_o.wasel = WASEL_RT; sel_o.wdsel = WDSEL_ALU; end
      OP_LW: begin
        fn          = ALU_ADD;
        sel_o.kind  = K_LOAD;
        sel_o.bsel  = 1'b1;
        sel_o.sext  = 1'b1;
        sel_o.wasel = WASEL_RT;
        sel_o.wdsel = WDSEL_MEM;
      end
      OP_SW: begin
        fn         = ALU_ADD;
        sel_o.kind = K_STORE;
        sel_o.bsel = 1'b1;
        sel_o.sext = 1'b1;
      end
      OP_BEQ: begin fn = ALU_SUB; sel_o.kind = K_JUMP; sel_o.br = BR_EQ; sel_o.sext = 1'b1; end
      OP_BNE: begin fn = ALU_SUB; sel_o.kind = K_JUMP; sel_o.br = BR_NE; sel_o.sext = 1'b1; end
      OP_J:   begin sel_o.kind = K_JUMP; sel_o.pcsel = PCSEL_JMP; end
      OP_JAL: begin
        sel_o.kind  = K_LINK;
        sel_o.pcsel = PCSEL_JMP;
        sel_o.wasel = WASEL_RA;
        sel_o.wdsel = WDSEL_LINK;
      end
      default: illegal_o = 1'b1;
    endcase
  end

  assign alufn_o = ALUFN_W'(fn);

endmodule

// File: rtl/mc_controller.sv
// Multicycle processor controller: fetch/decode/exec/mem/writeback FSM with
// memory-handshake timeout and sticky fault.
module mc_controller
  import mc_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter int unsigned ALUFN_W     = 5
) (
  input  logic            clk,
  input  logic            reset,
  mc_controller_if.master bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               timeout;
  logic               mem_req_c, mem_we_c, irwrite_c, pcwrite_c, werf_c;
  logic               sel_en;
  logic [1:0]         pcsel_c;

  logic [ALUFN_W-1:0] dec_alufn;
  dec_t               dec_sel;
  logic               dec_illegal;

  mc_alu_decoder #(.ALUFN_W(ALUFN_W)) u_dec (
    .op_i      (bus.op),
    .func_i    (bus.func),
    .alufn_o   (dec_alufn),
    .sel_o     (dec_sel),
    .illegal_o (dec_illegal)
  );

  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYC));

  // State and wait-counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, wait counter and strobes; ready beats a coincident timeout
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_req_c = 1'b0;
    mem_we_c  = 1'b0;
    irwrite_c = 1'b0;
    pcwrite_c = 1'b0;
    werf_c    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        if (bus.mem_ready) begin
          irwrite_c = 1'b1;
          state_d   = S_DECODE;
        end else if (timeout) begin
          state_d = S_FAULT;
        end
      end
      S_DECODE: state_d = dec_illegal ? S_FAULT : S_EXEC;
      S_EXEC: begin
        case (dec_sel.kind)
          K_JUMP: begin
            pcwrite_c = 1'b1;
            state_d   = S_FETCH;
          end
          K_LOAD, K_STORE: state_d = S_MEM;
          default:         state_d = S_WB;
        endcase
      end
      S_MEM: begin
        mem_req_c = 1'b1;
        mem_we_c  = (dec_sel.kind == K_STORE);
        if (bus.mem_ready) begin
          if (dec_sel.kind == K_STORE) begin
            pcwrite_c = 1'b1;
            state_d   = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout) begin
          state_d = S_FAULT;
        end
      end
      S_WB: begin
        werf_c    = 1'b1;
        pcwrite_c = 1'b1;
        state_d   = S_FETCH;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase

    // Every state change starts a fresh handshake window
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (mem_req_c && !bus.mem_ready) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Frozen or in reset: hold everything and issue nothing
    if (!bus.enable || reset) begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mem_req_c = 1'b0;
      mem_we_c  = 1'b0;
      irwrite_c = 1'b0;
      pcwrite_c = 1'b0;
      werf_c    = 1'b0;
    end
  end

  // Resolve conditional branches against the ALU zero flag
  always_comb begin
    pcsel_c = dec_sel.pcsel;
    if (dec_sel.br == BR_EQ) begin
      pcsel_c = bus.Z ? PCSEL_BR : PCSEL_INC;
    end else if (dec_sel.br == BR_NE) begin
      pcsel_c = bus.Z ? PCSEL_INC : PCSEL_BR;
    end
  end

  // Selects only carry instruction controls once the IR is loaded
  assign sel_en = (state_q == S_DECODE) || (state_q == S_EXEC) ||
                  (state_q == S_MEM)    || (state_q == S_WB);

  assign bus.mem_req = mem_req_c;
  assign bus.mem_we  = mem_we_c;
  assign bus.irwrite = irwrite_c;
  assign bus.pcwrite = pcwrite_c;
  assign bus.werf    = werf_c;
  assign bus.pcsel   = sel_en ? pcsel_c       : 2'b00;
  assign bus.wasel   = sel_en ? dec_sel.wasel : 2'b00;
  assign bus.wdsel   = sel_en ? dec_sel.wdsel : 2'b00;
  assign bus.asel    = sel_en ? dec_sel.asel  : 2'b00;
  assign bus.sext    = sel_en && dec_sel.sext;
  assign bus.bsel    = sel_en && dec_sel.bsel;
  assign bus.alufn   = sel_en ? dec_alufn     : '0;
  assign bus.state   = state_q;
  assign bus.fault   = (state_q == S_FAULT);

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller; cycle 1 is the first cycle after reset release.
module tb_mc_controller;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  mc_controller_if #(.ALUFN_W(5)) bus ();

  mc_controller #(.TIMEOUT_CYC(4), .ALUFN_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse reset, verify the reset image, release at a falling edge
  task automatic do_reset();
    reset = 1'b0;
    bus.mem_ready = 1'b0;
    bus.Z = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    chk("rst_state",   32'(bus.state),   32'd0);
    chk("rst_fault",   32'(bus.fault),   32'd0);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_strobes", 32'({bus.mem_we, bus.irwrite, bus.pcwrite, bus.werf}), 32'd0);
    chk("rst_selects", 32'({bus.pcsel, bus.wasel, bus.wdsel, bus.asel, bus.sext, bus.bsel}), 32'd0);
    chk("rst_alufn",   32'(bus.alufn),   32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    bus.enable    = 1'b1;
    bus.op        = 6'h00;
    bus.func      = 6'h20;
    bus.Z         = 1'b0;
    bus.mem_ready = 1'b0;

    // ADD, zero wait: 4-cycle instruction
    do_reset();
    bus.mem_ready = 1'b1; #1;
    chk("add_c1_irwrite", 32'(bus.irwrite), 32'd1);
    chk("add_c1_mem_req", 32'(bus.mem_req), 32'd1);
    chk("add_c1_no_wr",   32'({bus.mem_we, bus.pcwrite, bus.werf}), 32'd0);
    @(negedge clk); bus.mem_ready = 1'b0; #1;
    chk("add_c2_state",   32'(bus.state),   32'd1);
    chk("add_c2_mem_req", 32'(bus.mem_req), 32'd0);
    @(negedge clk); #1;
    chk("add_c3_state",   32'(bus.state),   32'd2);
    chk("add_c3_alufn",   32'(bus.alufn),   32'h01);
    chk("add_c3_pcwrite", 32'(bus.pcwrite), 32'd0);
    @(negedge clk); #1;
    chk("add_c4_state",   32'(bus.state),   32'd4);
    chk("add_c4_werf",    32'(bus.werf),    32'd1);
    chk("add_c4_pcwrite", 32'(bus.pcwrite), 32'd1);
    chk("add_c4_alufn",   32'(bus.alufn),   32'h01);
    chk("add_c4_wdsel",   32'(bus.wdsel),   32'd1);
    chk("add_c4_wasel",   32'(bus.wasel),   32'd0);
    @(negedge clk); #1;
    chk("add_c5_state",   32'(bus.state),   32'd0);
    chk("add_c5_mem_req", 32'(bus.mem_req), 32'd1);

    // BEQ taken then BNE not taken, both with Z=1
    bus.op = 6'h04;
    do_reset();
    bus.mem_ready = 1'b1; #1;
    chk("beq_c1_irwrite", 32'(bus.irwrite), 32'd1);
    @(negedge clk); bus.mem_ready = 1'b0;
    @(negedge clk); bus.Z = 1'b1; #1;
    chk("beq_c3_state",   32'(bus.state),   32'd2);
    chk("beq_c3_pcwrite", 32'(bus.pcwrite), 32'd1);
    chk("beq_c3_pcsel",   32'(bus.pcsel),   32'd1);
    chk("beq_c3_werf",    32'(bus.werf),    32'd0);
    chk("beq_c3_alufn",   32'(bus.alufn),   32'h03);
    @(negedge clk); bus.Z = 1'b0; bus.op = 6'h05; bus.mem_ready = 1'b1; #1;
    chk("beq_c4_state",   32'(bus.state),   32'd0);
    chk("bne_c1_irwrite", 32'(bus.irwrite), 32'd1);
    @(negedge clk); bus.mem_ready = 1'b0;
    @(negedge clk); bus.Z = 1'b1; #1;
    chk("bne_c3_pcwrite", 32'(bus.pcwrite), 32'd1);
    chk("bne_c3_pcsel",   32'(bus.pcsel),   32'd0);
    @(negedge clk); bus.Z = 1'b0; #1;
    chk("bne_c4_state",   32'(bus.state),   32'd0);

    // JAL: link written in WB via r31
    bus.op = 6'h03;
    do_reset();
    bus.mem_ready = 1'b1;
    @(negedge clk); bus.mem_ready = 1'b0;
    @(negedge clk); #1;
    chk("jal_c3_pcwrite", 32'(bus.pcwrite), 32'd0);
    @(negedge clk); #1;
    chk("jal_c4_state",   32'(bus.state),   32'd4);
    chk("jal_c4_wr",      32'({bus.werf, bus.pcwrite}), 32'd3);
    chk("jal_c4_pcsel",   32'(bus.pcsel),   32'd2);
    chk("jal_c4_wasel",   32'(bus.wasel),   32'd2);
    chk("jal_c4_wdsel",   32'(bus.wdsel),   32'd0);

    // LW with three wait cycles in MEM
    bus.op = 6'h23;
    do_reset();
    bus.mem_ready = 1'b1;
    @(negedge clk); bus.mem_ready = 1'b0;
    @(negedge clk);
    for (int i = 4; i <= 6; i++) begin
      @(negedge clk); #1;
      chk($sformatf("lw_c%0d_state", i),   32'(bus.state),   32'd3);
      chk($sformatf("lw_c%0d_mem_req", i), 32'(bus.mem_req), 32'd1);
      chk($sformatf("lw_c%0d_mem_we", i),  32'(bus.mem_we),  32'd0);
    end
    @(negedge clk); bus.mem_ready = 1'b1; #1;
    chk("lw_c7_mem_we",   32'(bus.mem_we),  32'd0);
    chk("lw_c7_strobes",  32'({bus.werf, bus.pcwrite}), 32'd0);
    @(negedge clk); bus.mem_ready = 1'b0; #1;
    chk("lw_c8_state",    32'(bus.state),   32'd4);
    chk("lw_c8_werf",     32'(bus.werf),    32'd1);
    chk("lw_c8_wdsel",    32'(bus.wdsel),   32'd2);
    chk("lw_c8_fault",    32'(bus.fault),   32'd0);

    // SW zero wait, then a second SW frozen in MEM and aborted by reset
    bus.op = 6'h2B;
    do_reset();
    bus.mem_ready = 1'b1;
    @(negedge clk); bus.mem_ready = 1'b0;
    @(negedge clk); #1;
    chk("sw_c3_bsel_sext", 32'({bus.bsel, bus.sext}), 32'd3);
    @(negedge clk); bus.mem_ready = 1'b1; #1;
    chk("sw_c4_state",    32'(bus.state),   32'd3);
    chk("sw_c4_mem_we",   32'(bus.mem_we),  32'd1);
    chk("sw_c4_pcwrite",  32'(bus.pcwrite), 32'd1);
    chk("sw_c4_werf",     32'(bus.werf),    32'd0);
    @(negedge clk); #1;
    chk("sw_c5_state",    32'(bus.state),   32'd0);
    chk("sw_c5_irwrite",  32'(bus.irwrite), 32'd1);
    chk("sw_c5_mem_we",   32'(bus.mem_we),  32'd0);
    @(negedge clk); bus.mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk); bus.enable = 1'b0; #1;
    chk("swf_c8_state",   32'(bus.state),   32'd3);
    chk("swf_c8_strobes", 32'({bus.mem_req, bus.mem_we, bus.pcwrite, bus.werf}), 32'd0);
    @(negedge clk); bus.mem_ready = 1'b1; #1;
    chk("swf_c9_state",   32'(bus.state),   32'd3);
    chk("swf_c9_strobes", 32'({bus.mem_req, bus.mem_we, bus.pcwrite, bus.werf}), 32'd0);
    do_reset();
    bus.enable = 1'b1; #1;
    chk("swf_post_state",   32'(bus.state),   32'd0);
    chk("swf_post_mem_req", 32'(bus.mem_req), 32'd1);
    chk("swf_post_mem_we",  32'(bus.mem_we),  32'd0);

    // Illegal opcode faults out of DECODE
    bus.op = 6'h3F;
    do_reset();
    bus.mem_ready = 1'b1;
    @(negedge clk); bus.mem_ready = 1'b0; #1;
    chk("ill_c2_state",   32'(bus.state),   32'd1);
    chk("ill_c2_werf",    32'(bus.werf),    32'd0);
    @(negedge clk); #1;
    chk("ill_c3_state",   32'(bus.state),   32'd5);
    chk("ill_c3_fault",   32'(bus.fault),   32'd1);
    chk("ill_c3_strobes", 32'({bus.mem_req, bus.mem_we, bus.pcwrite, bus.werf}), 32'd0);
    @(negedge clk); bus.mem_ready = 1'b1; #1;
    chk("ill_c4_state",   32'(bus.state),   32'd5);
    chk("ill_c4_irwrite", 32'(bus.irwrite), 32'd0);

    // Fetch timeout: counts 0..4 in FETCH, faults on the cycle the count reaches 4
    bus.op = 6'h00; bus.func = 6'h20;
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      #1;
      chk($sformatf("to_c%0d_state", i),   32'(bus.state),   32'd0);
      chk($sformatf("to_c%0d_mem_req", i), 32'(bus.mem_req), 32'd1);
      @(negedge clk);
    end
    #1;
    chk("to_c6_state",    32'(bus.state),   32'd5);
    chk("to_c6_fault",    32'(bus.fault),   32'd1);
    chk("to_c6_mem_req",  32'(bus.mem_req), 32'd0);
    @(negedge clk); bus.enable = 1'b0;
    @(negedge clk); bus.enable = 1'b1; bus.mem_ready = 1'b1; #1;
    chk("to_c8_state",    32'(bus.state),   32'd5);
    chk("to_c8_fault",    32'(bus.fault),   32'd1);
    chk("to_c8_mem_req",  32'(bus.mem_req), 32'd0);

    // Ready arriving on the timeout cycle completes the fetch
    do_reset();
    repeat (4) @(negedge clk);
    bus.mem_ready = 1'b1; #1;
    chk("race_c5_irwrite", 32'(bus.irwrite), 32'd1);
    @(negedge clk); bus.mem_ready = 1'b0; #1;
    chk("race_c6_state",   32'(bus.state),   32'd1);
    chk("race_c6_fault",   32'(bus.fault),   32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
